ram32x8_fifo_ctrl: RTL and testbench
====================================

# ram32x8_fifo_ctrl

Sequencing controller for the 32-word x 8-bit structural RAM, turning it into a synchronous FIFO. Accepts write/read requests, gates them against full/empty state, generates the RAM write/read addresses and strobes, and tracks occupancy. The RAM's internal address decode (3-to-8 bank/row select) consumes the addresses produced here. The controller carries no data; the 8-bit data path runs directly between the user and the RAM.

## Interface
Parameters:
- DEPTH, 32: number of RAM words. Fixed to 32 for this RAM.
- ADDR_W, 5: pointer/address width, log2(DEPTH).
- AF_LEVEL, 28: almost-full threshold, used only with the macro in Configuration.
- AE_LEVEL, 4: almost-empty threshold, used only with the macro in Configuration.

Ports:
- Clk, in, 1: single clock. All state updates on the rising edge.
- Rst_n, in, 1: synchronous, active-low reset.
- WrReq, in, 1: write request for the current cycle.
- RdReq, in, 1: read request for the current cycle.
- ErrClr, in, 1: clears the sticky error flags.
- WrEn, out, 1: RAM write strobe; WrReq & ~Full (combinational).
- RdEn, out, 1: RAM read strobe; RdReq & ~Empty (combinational).
- WrAddr, out, ADDR_W: RAM write address, equal to the registered write pointer.
- RdAddr, out, ADDR_W: RAM read address, equal to the registered read pointer.
- RdValid, out, 1: RAM read data valid; RdEn delayed by one cycle.
- Full, out, 1: Count == 32 (registered).
- Empty, out, 1: Count == 0 (registered).
- Count, out, ADDR_W+1: current occupancy, 0 to 32.
- Overflow, out, 1: sticky; set by WrReq while Full.
- Underflow, out, 1: sticky; set by RdReq while Empty.

## Operation
- Write accepted (WrEn = 1): the RAM stores at WrAddr on this edge, and the write pointer increments.
- Read accepted (RdEn = 1): the RAM reads RdAddr, and the read pointer increments.
- Pointers wrap modulo 32 (31 goes to 0). No extra wrap bit is kept; Count disambiguates full from empty.
- Count update:
  - Write only: +1.
  - Read only: -1.
  - Both accepted, or neither: unchanged.
- Full and Empty are decoded from the next Count and registered, so they are valid at the start of every cycle.
- Full with simultaneous WrReq and RdReq: the read is accepted and the write is rejected. Overflow is set, and Count goes to 31.
- Empty with simultaneous WrReq and RdReq: the write is accepted and the read is rejected. Underflow is set, and Count goes to 1. There is no fall-through.
- A rejected request leaves the pointers, Count and the RAM unchanged.
- ErrClr clears Overflow and Underflow. If a new error occurs in the same cycle as ErrClr, the set wins.
- Count is never allowed outside the range 0 to 32.

## Timing
- Rst_n low at an edge sets every register, regardless of requests in the same cycle:
  - Pointers = 0, Count = 0, Empty = 1, Full = 0.
  - RdValid = 0, Overflow = 0, Underflow = 0.
- While Rst_n is low, WrEn and RdEn are forced to 0.
- Reset in the middle of operation discards the contents. RAM data is not cleared, but becomes unreachable.
- Strobe latency: WrEn and RdEn follow their requests in the same cycle (zero latency).
- Read latency: RAM data is sampled when RdValid = 1, one cycle after RdEn.
- Flag latency: Full, Empty and Count reflect an accepted operation one cycle after the accepting edge.
- Back-to-back accepted reads and writes are sustained at 1 per cycle each.

## Configuration
- The macro RAM32X8_FIFO_CTRL_ALMOST_EN is the single compile-time option.
- Defined: adds the outputs AlmostFull (Count >= AF_LEVEL) and AlmostEmpty (Count <= AE_LEVEL). Both are registered from the next Count. Reset values are AlmostFull = 0 and AlmostEmpty = 1.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

## Structure
- Package ram32x8_fifo_pkg holds:
  - The constants DEPTH = 32, ADDR_W = 5 and CNT_W = 6.
  - The default AF_LEVEL and AE_LEVEL.
- Sub-module fifo_ptr_cnt: a 5-bit wrapping counter with synchronous active-low reset and an increment enable. It is instantiated twice, once as the write pointer and once as the read pointer.
- The Count, flag and error logic stay in the top module.

## Test plan
- Reset, then 32 writes:
  - WrAddr steps 0 to 31.
  - Full rises after the 32nd edge, and Count = 32.
  - A 33rd WrReq gives WrEn = 0 and Overflow = 1.
- Read 32 words after the fill:
  - RdAddr steps 0 to 31.
  - RdValid follows each RdEn by 1 cycle.
  - Empty = 1 at the end.
  - One more RdReq sets Underflow.
- Wrap: write 20, read 20, write 20. WrAddr goes 20 to 31 then 0 to 7, and Count = 20.
- Simultaneous requests:
  - At Count = 32, WrReq = RdReq = 1 gives Count 31 and sets Overflow.
  - At Count = 0, the same requests give Count 1 and set Underflow.
  - At Count = 10, the same requests leave Count at 10 and move both pointers.
- Reset mid-stream: Rst_n low at Count = 17 gives Count = 0, Empty = 1 and both pointers 0 on the next cycle.
- With the macro defined: AlmostFull asserts at Count 28, and AlmostEmpty deasserts at Count 5.

Source files
------------

// File: rtl/ram32x8_fifo_pkg.sv
// Shared constants for the 32x8 RAM FIFO controller.
package ram32x8_fifo_pkg;

    localparam int unsigned DEPTH            = 32;
    localparam int unsigned ADDR_W           = 5;
    localparam int unsigned CNT_W            = 6;
    localparam int unsigned AF_LEVEL_DEFAULT = 28;
    localparam int unsigned AE_LEVEL_DEFAULT = 4;

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Wrapping address pointer with increment enable and synchronous active-low reset.
module fifo_ptr_cnt
    import ram32x8_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = ADDR_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [WIDTH-1:0] ptr_o
);

    logic [WIDTH-1:0] ptr_q, ptr_d;

    // Natural binary overflow gives the modulo-DEPTH wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = ptr_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/ram32x8_fifo_ctrl.sv
// FIFO sequencing controller for the 32x8 RAM: pointers, occupancy, flags and sticky errors.
// Define RAM32X8_FIFO_CTRL_ALMOST_EN to add registered AlmostFull/AlmostEmpty outputs.
module ram32x8_fifo_ctrl
    import ram32x8_fifo_pkg::*;
#(
    parameter int unsigned DEPTH    = ram32x8_fifo_pkg::DEPTH,
    parameter int unsigned ADDR_W   = ram32x8_fifo_pkg::ADDR_W,
    parameter int unsigned AF_LEVEL = AF_LEVEL_DEFAULT,
    parameter int unsigned AE_LEVEL = AE_LEVEL_DEFAULT
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              WrReq,
    input  logic              RdReq,
    input  logic              ErrClr,
    output logic              WrEn,
    output logic              RdEn,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [ADDR_W-1:0] RdAddr,
    output logic              RdValid,
    output logic              Full,
    output logic              Empty,
    output logic [ADDR_W:0]   Count,
    output logic              Overflow,
    output logic              Underflow
`ifdef RAM32X8_FIFO_CTRL_ALMOST_EN
    ,
    output logic              AlmostFull,
    output logic              AlmostEmpty
`endif
);

    localparam int unsigned CW = ADDR_W + 1;

    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          rdvalid_q;
    logic          wr_en, rd_en;

    // Strobes are gated by reset so nothing reaches the RAM while Rst_n is low.
    always_comb begin
        wr_en = Rst_n & WrReq & ~full_q;
        rd_en = Rst_n & RdReq & ~empty_q;
    end

    fifo_ptr_cnt #(
        .WIDTH (ADDR_W)
    ) u_wr_ptr (
        .clk_i  (Clk),
        .rst_ni (Rst_n),
        .inc_i  (wr_en),
        .ptr_o  (WrAddr)
    );

    fifo_ptr_cnt #(
        .WIDTH (ADDR_W)
    ) u_rd_ptr (
        .clk_i  (Clk),
        .rst_ni (Rst_n),
        .inc_i  (rd_en),
        .ptr_o  (RdAddr)
    );

    always_comb begin
        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d      = (count_d == CW'(DEPTH));
        empty_d     = (count_d == '0);
        // A new error in the same cycle as ErrClr keeps the flag set.
        overflow_d  = (overflow_q & ~ErrClr) | (WrReq & full_q);
        underflow_d = (underflow_q & ~ErrClr) | (RdReq & empty_q);
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rdvalid_q   <= 1'b0;
        end else begin
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            rdvalid_q   <= rd_en;
        end
    end

    assign WrEn      = wr_en;
    assign RdEn      = rd_en;
    assign RdValid   = rdvalid_q;
    assign Full      = full_q;
    assign Empty     = empty_q;
    assign Count     = count_q;
    assign Overflow  = overflow_q;
    assign Underflow = underflow_q;

`ifdef RAM32X8_FIFO_CTRL_ALMOST_EN
    logic afull_q, aempty_q;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            afull_q  <= (count_d >= CW'(AF_LEVEL));
            aempty_q <= (count_d <= CW'(AE_LEVEL));
        end
    end

    assign AlmostFull  = afull_q;
    assign AlmostEmpty = aempty_q;
`else
    logic unused_levels;
    assign unused_levels = ^{AF_LEVEL, AE_LEVEL};
`endif

endmodule

// File: tb/tb_ram32x8_fifo_ctrl.sv
// Self-checking bench for ram32x8_fifo_ctrl: vector table, directed corners, randomized vs model.
module tb_ram32x8_fifo_ctrl;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       WrReq = 1'b0;
    logic       RdReq = 1'b0;
    logic       ErrClr = 1'b0;
    logic       WrEn, RdEn, RdValid, Full, Empty, Overflow, Underflow;
    logic [4:0] WrAddr, RdAddr;
    logic [5:0] Count;
`ifdef RAM32X8_FIFO_CTRL_ALMOST_EN
    logic       AlmostFull, AlmostEmpty;
`endif

    ram32x8_fifo_ctrl dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .WrReq     (WrReq),
        .RdReq     (RdReq),
        .ErrClr    (ErrClr),
        .WrEn      (WrEn),
        .RdEn      (RdEn),
        .WrAddr    (WrAddr),
        .RdAddr    (RdAddr),
        .RdValid   (RdValid),
        .Full      (Full),
        .Empty     (Empty),
        .Count     (Count),
        .Overflow  (Overflow),
`ifdef RAM32X8_FIFO_CTRL_ALMOST_EN
        .AlmostFull  (AlmostFull),
        .AlmostEmpty (AlmostEmpty),
`endif
        .Underflow (Underflow)
    );

    always #5 Clk = ~Clk;

    // Behavioural RAM driven by the controller's strobes and addresses.
    logic [7:0] mem [32];
    logic [7:0] ram_rdata;
    logic [7:0] wdata;
    always @(posedge Clk) begin
        if (WrEn) mem[WrAddr] <= wdata;
        if (RdEn) ram_rdata <= mem[RdAddr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: FIFO contents as a queue, pointers as totals modulo 32.
    logic [7:0] q[$];
    int  wr_total, rd_total;
    bit  m_ovf, m_unf, m_rv, m_known;
    logic [7:0] m_rexp;

    // Samples taken just before the edge of the most recent cycle.
    bit       s_wren, s_rden, s_rv;
    int       s_wraddr, s_rdaddr;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit rstn, input bit wr, input bit rd, input bit clr);
        bit acc_w, acc_r;
        int occ;
        @(negedge Clk);
        Rst_n  = rstn;
        WrReq  = wr;
        RdReq  = rd;
        ErrClr = clr;
        wdata  = 8'($urandom);
        #1;
        occ   = q.size();
        acc_w = rstn && wr && (occ < 32);
        acc_r = rstn && rd && (occ > 0);
        s_wren   = WrEn;
        s_rden   = RdEn;
        s_wraddr = int'(WrAddr);
        s_rdaddr = int'(RdAddr);
        s_rv     = RdValid;
        if (m_known) begin
            chk("wren", WrEn, acc_w);
            chk("rden", RdEn, acc_r);
            chk("wraddr", WrAddr, wr_total % 32);
            chk("rdaddr", RdAddr, rd_total % 32);
            chk("count", Count, occ);
            chk("full", Full, occ == 32);
            chk("empty", Empty, occ == 0);
            chk("overflow", Overflow, m_ovf);
            chk("underflow", Underflow, m_unf);
            chk("rdvalid", RdValid, m_rv);
            if (m_rv) chk("rdata", ram_rdata, m_rexp);
`ifdef RAM32X8_FIFO_CTRL_ALMOST_EN
            chk("almost_full", AlmostFull, occ >= 28);
            chk("almost_empty", AlmostEmpty, occ <= 4);
`endif
        end else begin
            chk("wren_in_reset", WrEn, 0);
            chk("rden_in_reset", RdEn, 0);
        end
        @(posedge Clk);
        if (!rstn) begin
            q.delete();
            wr_total = 0;
            rd_total = 0;
            m_ovf    = 0;
            m_unf    = 0;
            m_rv     = 0;
            m_known  = 1;
        end else if (m_known) begin
            m_ovf = (m_ovf && !clr) || (wr && occ == 32);
            m_unf = (m_unf && !clr) || (rd && occ == 0);
            m_rv  = acc_r;
            if (acc_r) begin
                m_rexp = q.pop_front();
                rd_total++;
            end
            if (acc_w) begin
                q.push_back(wdata);
                wr_total++;
            end
        end
    endtask

    typedef struct {
        bit rstn, wr, rd, clr;
        bit e_wren, e_rden;
        int e_cnt;
        bit e_full, e_empty, e_ovf, e_unf;
    } vec_t;

    function automatic vec_t mk(bit rstn, bit wr, bit rd, bit clr, bit ew, bit er, int ec,
                                bit ef, bit ee, bit eo, bit eu);
        vec_t v;
        v.rstn = rstn; v.wr = wr; v.rd = rd; v.clr = clr;
        v.e_wren = ew; v.e_rden = er; v.e_cnt = ec;
        v.e_full = ef; v.e_empty = ee; v.e_ovf = eo; v.e_unf = eu;
        return v;
    endfunction

    vec_t vecs[12];

    task automatic after_edge(input string name, input int cnt, input bit full, input bit empty);
        #1;
        chk({name, "_count"}, Count, cnt);
        chk({name, "_full"}, Full, full);
        chk({name, "_empty"}, Empty, empty);
    endtask

    initial begin
        // rstn wr rd clr | wren rden | count full empty ovf unf (after the edge)
        vecs[0]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        vecs[1]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1);
        vecs[2]  = mk(1, 1, 1, 0, 1, 0, 1, 0, 0, 0, 1);
        vecs[3]  = mk(1, 1, 0, 1, 1, 0, 2, 0, 0, 0, 0);
        vecs[4]  = mk(1, 1, 1, 0, 1, 1, 2, 0, 0, 0, 0);
        vecs[5]  = mk(1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        vecs[6]  = mk(1, 0, 1, 1, 0, 1, 0, 0, 1, 0, 0);
        vecs[7]  = mk(1, 0, 1, 1, 0, 0, 0, 0, 1, 0, 1);
        vecs[8]  = mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        vecs[9]  = mk(1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        vecs[10] = mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        vecs[11] = mk(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1);

        m_known = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].rstn, vecs[i].wr, vecs[i].rd, vecs[i].clr);
            chk($sformatf("vec%0d_wren", i), s_wren, vecs[i].e_wren);
            chk($sformatf("vec%0d_rden", i), s_rden, vecs[i].e_rden);
            after_edge($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_full, vecs[i].e_empty);
            chk($sformatf("vec%0d_ovf", i), Overflow, vecs[i].e_ovf);
            chk($sformatf("vec%0d_unf", i), Underflow, vecs[i].e_unf);
        end

        // Fill 32, overflow on the 33rd, drain 32, underflow on one more.
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            cycle(1, 1, 0, 0);
            chk("fill_wraddr", s_wraddr, i);
        end
        after_edge("filled", 32, 1, 0);
        cycle(1, 1, 0, 0);
        chk("ovf_wren", s_wren, 0);
        #1 chk("ovf_set", Overflow, 1);
        for (int i = 0; i < 32; i++) begin
            cycle(1, 0, 1, 0);
            chk("drain_rdaddr", s_rdaddr, i);
            chk("drain_rden", s_rden, 1);
            #1 chk("drain_rdvalid", RdValid, 1);
        end
        after_edge("drained", 0, 0, 1);
        cycle(1, 0, 1, 0);
        chk("unf_rden", s_rden, 0);
        #1;
        chk("unf_set", Underflow, 1);
        chk("unf_rdvalid", RdValid, 0);

        // Simultaneous requests at full, at empty and mid-level.
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 32; i++) cycle(1, 1, 0, 0);
        cycle(1, 1, 1, 0);
        after_edge("both_full", 31, 0, 0);
        chk("both_full_ovf", Overflow, 1);
        cycle(0, 0, 0, 0);
        cycle(1, 1, 1, 0);
        after_edge("both_empty", 1, 0, 0);
        chk("both_empty_unf", Underflow, 1);
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0);
        cycle(1, 1, 1, 0);
        after_edge("both_mid", 10, 0, 0);
        chk("both_mid_wraddr", WrAddr, 11);
        chk("both_mid_rdaddr", RdAddr, 1);

        // Wrap: write 20, read 20, write 20.
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle(1, 1, 0, 0);
        for (int i = 0; i < 20; i++) cycle(1, 0, 1, 0);
        for (int i = 0; i < 20; i++) begin
            cycle(1, 1, 0, 0);
            chk("wrap_wraddr", s_wraddr, (20 + i) % 32);
        end
        after_edge("wrap", 20, 0, 0);

        // Reset mid-stream at 17.
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 17; i++) cycle(1, 1, 0, 0);
        #1 chk("mid_pre_count", Count, 17);
        cycle(0, 1, 1, 0);
        chk("mid_rst_wren", s_wren, 0);
        after_edge("mid_rst", 0, 0, 1);
        chk("mid_rst_wraddr", WrAddr, 0);
        chk("mid_rst_rdaddr", RdAddr, 0);

`ifdef RAM32X8_FIFO_CTRL_ALMOST_EN
        cycle(0, 0, 0, 0);
        #1 chk("ae_reset", AlmostEmpty, 1);
        chk("af_reset", AlmostFull, 0);
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0);
        #1 chk("ae_at4", AlmostEmpty, 1);
        cycle(1, 1, 0, 0);
        #1 chk("ae_at5", AlmostEmpty, 0);
        for (int i = 0; i < 22; i++) cycle(1, 1, 0, 0);
        #1 chk("af_at27", AlmostFull, 0);
        cycle(1, 1, 0, 0);
        #1 chk("af_at28", AlmostFull, 1);
`endif

        // Randomized traffic in phases biased towards filling, draining and balance.
        cycle(0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            int phase;
            bit wr, rd, clr, rstn;
            phase = (n / 150) % 3;
            wr    = ($urandom_range(0, 9) < (phase == 0 ? 8 : (phase == 1 ? 2 : 5)));
            rd    = ($urandom_range(0, 9) < (phase == 0 ? 2 : (phase == 1 ? 8 : 5)));
            clr   = ($urandom_range(0, 15) == 0);
            rstn  = ($urandom_range(0, 299) != 0);
            cycle(rstn, wr, rd, clr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
